get_frame_length_and_timestamp_wide: RTL and testbench



---
 rtl/get_frame_length_and_timestamp_wide.sv | 143 ++++++++++++++
 tb/tb_get_frame_length_and_timestamp_wide.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/get_frame_length_and_timestamp_wide.sv
`default_nettype none
// ============================================================================
// Module   : get_frame_length_and_timestamp_wide
// Purpose  : AXI4-Stream frame pass-through that emits one {frame_length,
//            timestamp} metadata beat per frame through a small FIFO.
//            Optional: GET_FRAME_LENGTH_AND_TIMESTAMP_WIDE_EOF_TIMESTAMP_EN
//            moves timestamp capture from the first beat to the tlast beat.
// Revision : 1.0 - initial release
// ============================================================================
module get_frame_length_and_timestamp_wide #(
  parameter int DATA_WIDTH         = 64,
  parameter int KEEP_WIDTH         = DATA_WIDTH / 8,
  parameter int FRAME_LENGTH_WIDTH = 16,
  parameter int TIMESTAMP_WIDTH    = 72,
  parameter int META_FIFO_DEPTH    = 4
) (
  input  logic                                        clk,
  input  logic                                        rstn,
  input  logic [TIMESTAMP_WIDTH-1:0]                  ats_scheduler_timer,

  input  logic [DATA_WIDTH-1:0]                       s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]                       s_axis_tkeep,
  input  logic                                        s_axis_tvalid,
  output logic                                        s_axis_tready,
  input  logic                                        s_axis_tlast,

  output logic [DATA_WIDTH-1:0]                       m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]                       m_axis_tkeep,
  output logic                                        m_axis_tvalid,
  input  logic                                        m_axis_tready,
  output logic                                        m_axis_tlast,

  output logic [FRAME_LENGTH_WIDTH+TIMESTAMP_WIDTH-1:0] m_axis_meta_tdata,
  output logic                                        m_axis_meta_tvalid,
  input  logic                                        m_axis_meta_tready,

  output logic                                        in_frame
);

  localparam int c_META_WIDTH = FRAME_LENGTH_WIDTH + TIMESTAMP_WIDTH;
  localparam int c_ADDR_WIDTH = $clog2(META_FIFO_DEPTH);
  localparam int c_SUM_WIDTH  = FRAME_LENGTH_WIDTH + 8;
  localparam logic [c_SUM_WIDTH-1:0] c_LEN_MAX = {8'd0, {FRAME_LENGTH_WIDTH{1'b1}}};

  logic                          r_in_frame;
  logic [FRAME_LENGTH_WIDTH-1:0] r_len;
  logic [c_ADDR_WIDTH:0]         r_wr_ptr;
  logic [c_ADDR_WIDTH:0]         r_rd_ptr;
  logic [c_META_WIDTH-1:0]       r_meta_mem [META_FIFO_DEPTH];

  logic                          w_meta_full;
  logic                          w_meta_empty;
  logic                          w_gate;
  logic                          w_accept;
  logic                          w_sof;
  logic                          w_eof;
  logic                          w_pop;
  logic [7:0]                    w_beat_bytes;
  logic [FRAME_LENGTH_WIDTH-1:0] w_len_base;
  logic [c_SUM_WIDTH-1:0]        w_sum;
  logic [FRAME_LENGTH_WIDTH-1:0] w_len_next;
  logic [TIMESTAMP_WIDTH-1:0]    w_push_ts;

  // Only the tlast beat is stalled on a full FIFO; body beats always flow.
  assign w_gate        = !(s_axis_tlast && w_meta_full);
  assign m_axis_tdata  = s_axis_tdata;
  assign m_axis_tkeep  = s_axis_tkeep;
  assign m_axis_tlast  = s_axis_tlast;
  assign m_axis_tvalid = s_axis_tvalid && w_gate;
  assign s_axis_tready = m_axis_tready && w_gate;

  assign w_accept = s_axis_tvalid && s_axis_tready;
  assign w_sof    = w_accept && !r_in_frame;
  assign w_eof    = w_accept && s_axis_tlast;
  assign in_frame = r_in_frame;

  always_comb begin
    w_beat_bytes = 8'd0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      w_beat_bytes = w_beat_bytes + 8'(s_axis_tkeep[i]);
    end
  end

  // Sum is computed wider than the length so saturation never wraps.
  assign w_len_base = w_sof ? '0 : r_len;
  assign w_sum      = {8'd0, w_len_base} + {{FRAME_LENGTH_WIDTH{1'b0}}, w_beat_bytes};
  assign w_len_next = (w_sum > c_LEN_MAX) ? '1 : w_sum[FRAME_LENGTH_WIDTH-1:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_in_frame <= 1'b0;
      r_len      <= '0;
    end else if (w_accept) begin
      r_in_frame <= !s_axis_tlast;
      r_len      <= w_len_next;
    end
  end

`ifdef GET_FRAME_LENGTH_AND_TIMESTAMP_WIDE_EOF_TIMESTAMP_EN
  assign w_push_ts = ats_scheduler_timer;
`else
  logic [TIMESTAMP_WIDTH-1:0] r_timestamp;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_timestamp <= '0;
    end else if (w_sof) begin
      r_timestamp <= ats_scheduler_timer;
    end
  end

  // A single-beat frame takes the live timer value.
  assign w_push_ts = w_sof ? ats_scheduler_timer : r_timestamp;
`endif

  assign w_meta_empty = (r_wr_ptr == r_rd_ptr);
  assign w_meta_full  = (r_wr_ptr[c_ADDR_WIDTH] != r_rd_ptr[c_ADDR_WIDTH]) &&
                        (r_wr_ptr[c_ADDR_WIDTH-1:0] == r_rd_ptr[c_ADDR_WIDTH-1:0]);
  assign w_pop        = m_axis_meta_tvalid && m_axis_meta_tready;

  assign m_axis_meta_tvalid = !w_meta_empty;
  assign m_axis_meta_tdata  = r_meta_mem[r_rd_ptr[c_ADDR_WIDTH-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < META_FIFO_DEPTH; i++) begin
        r_meta_mem[i] <= '0;
      end
    end else begin
      if (w_eof) begin
        r_meta_mem[r_wr_ptr[c_ADDR_WIDTH-1:0]] <= {w_len_next, w_push_ts};
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_get_frame_length_and_timestamp_wide.sv
`default_nettype none
// ============================================================================
// Module   : tb_get_frame_length_and_timestamp_wide
// Purpose  : Self-checking bench: directed table, FIFO-full and reset
//            sequences, then random traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_get_frame_length_and_timestamp_wide;

  localparam int DW    = 64;
  localparam int KW    = 8;
  localparam int FLW   = 16;
  localparam int TSW   = 72;
  localparam int DEPTH = 4;
  localparam int MW    = FLW + TSW;
  localparam int MW8   = 8 + TSW;

  logic           clk = 1'b0;
  logic           rstn;
  logic [TSW-1:0] timer;
  logic [DW-1:0]  s_tdata;
  logic [KW-1:0]  s_tkeep;
  logic           s_tvalid, s_tlast, m_tready, meta_tready;

  logic           s_tready, m_tvalid, m_tlast, meta_tvalid, in_frame;
  logic [DW-1:0]  m_tdata;
  logic [KW-1:0]  m_tkeep;
  logic [MW-1:0]  meta_tdata;

  logic           d8_s_tready, d8_m_tvalid, d8_m_tlast, d8_meta_tvalid, d8_in_frame;
  logic [DW-1:0]  d8_m_tdata;
  logic [KW-1:0]  d8_m_tkeep;
  logic [MW8-1:0] d8_meta_tdata;

  always #5 clk = ~clk;

  get_frame_length_and_timestamp_wide #(
    .DATA_WIDTH(DW), .FRAME_LENGTH_WIDTH(FLW), .TIMESTAMP_WIDTH(TSW), .META_FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .ats_scheduler_timer(timer),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .m_axis_meta_tdata(meta_tdata), .m_axis_meta_tvalid(meta_tvalid),
    .m_axis_meta_tready(meta_tready), .in_frame(in_frame)
  );

  // Narrow length counter instance for saturation coverage.
  get_frame_length_and_timestamp_wide #(
    .DATA_WIDTH(DW), .FRAME_LENGTH_WIDTH(8), .TIMESTAMP_WIDTH(TSW), .META_FIFO_DEPTH(DEPTH)
  ) dut8 (
    .clk(clk), .rstn(rstn), .ats_scheduler_timer(timer),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(d8_s_tready), .s_axis_tlast(s_tlast),
    .m_axis_tdata(d8_m_tdata), .m_axis_tkeep(d8_m_tkeep), .m_axis_tvalid(d8_m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(d8_m_tlast),
    .m_axis_meta_tdata(d8_meta_tdata), .m_axis_meta_tvalid(d8_meta_tvalid),
    .m_axis_meta_tready(meta_tready), .in_frame(d8_in_frame)
  );

  typedef struct {
    int             len;
    logic [TSW-1:0] ts;
  } meta_t;

  typedef struct {
    int        beats;
    logic [7:0] last_keep;
    int        exp_len;
    int        exp_len8;
  } vec_t;

  meta_t          q[$];
  int             n_cmp = 0;
  int             n_bad = 0;
  bit             m_in_frame;
  int             m_len;
  logic [TSW-1:0] m_ts;
  bit             last_acc;
  logic           sampled_tready;
  int             pops_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input int l);
    logic [31:0] v;
    v = l;
    return (l > 65535) ? 16'hFFFF : v[15:0];
  endfunction

  function automatic logic [7:0] sat8(input int l);
    logic [31:0] v;
    v = l;
    return (l > 255) ? 8'hFF : v[7:0];
  endfunction

  task automatic model_reset();
    q.delete();
    m_in_frame = 1'b0;
    m_len      = 0;
  endtask

  // One clock: compare at mid-cycle, advance the model, step to posedge+1.
  task automatic cycle();
    bit    gate, exp_rdy, acc, pop;
    meta_t e;
    #3;
    gate    = !(s_tlast && (q.size() == DEPTH));
    exp_rdy = m_tready && gate;
    sampled_tready = s_tready;
    chk("s_tready", 128'(s_tready), 128'(exp_rdy));
    chk("d8_s_tready", 128'(d8_s_tready), 128'(exp_rdy));
    chk("m_tvalid", 128'(m_tvalid), 128'(s_tvalid && gate));
    chk("passthru", 128'({m_tdata, m_tkeep, m_tlast}), 128'({s_tdata, s_tkeep, s_tlast}));
    chk("d8_passthru", 128'({d8_m_tdata, d8_m_tkeep, d8_m_tlast, d8_m_tvalid, d8_in_frame}),
        128'({s_tdata, s_tkeep, s_tlast, s_tvalid && gate, m_in_frame}));
    chk("in_frame", 128'(in_frame), 128'(m_in_frame));
    chk("meta_valid", 128'({meta_tvalid, d8_meta_tvalid}), 128'({2{q.size() != 0}}));
    if (q.size() != 0) begin
      chk("meta_data", 128'(meta_tdata), 128'({sat16(q[0].len), q[0].ts}));
      chk("meta8_data", 128'(d8_meta_tdata), 128'({sat8(q[0].len), q[0].ts}));
    end
    acc = s_tvalid && exp_rdy;
    pop = (q.size() != 0) && meta_tready;
    if (pop) begin
      void'(q.pop_front());
      pops_total++;
    end
    if (acc) begin
      if (!m_in_frame) begin
        m_len = 0;
        m_ts  = timer;
      end
      m_len += $countones(s_tkeep);
`ifdef GET_FRAME_LENGTH_AND_TIMESTAMP_WIDE_EOF_TIMESTAMP_EN
      if (s_tlast) m_ts = timer;
`endif
      if (s_tlast) begin
        e.len = m_len;
        e.ts  = m_ts;
        q.push_back(e);
        m_in_frame = 1'b0;
      end else begin
        m_in_frame = 1'b1;
      end
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    timer = timer + 72'd8000;
  endtask

  task automatic send_beat(input logic [KW-1:0] k, input bit l);
    int n;
    s_tdata  = {$urandom, $urandom};
    s_tkeep  = k;
    s_tlast  = l;
    s_tvalid = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: beat not accepted in %0d cycles, required 1", n);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int beats, input logic [KW-1:0] last_keep);
    for (int b = 0; b < beats - 1; b++) send_beat(8'hFF, 1'b0);
    send_beat(last_keep, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t           tbl[7];
    logic [TSW-1:0] t_first, t_exp;
    int             p0;

    tbl[0] = '{8,  8'hFF, 64,  64};
    tbl[1] = '{8,  8'h1F, 61,  61};
    tbl[2] = '{1,  8'h0F, 4,   4};
    tbl[3] = '{38, 8'h0F, 300, 255};
    tbl[4] = '{1,  8'h00, 0,   0};
    tbl[5] = '{2,  8'h01, 9,   9};
    tbl[6] = '{32, 8'hFF, 256, 255};

    rstn = 1'b0; timer = '0; s_tdata = '0; s_tkeep = '0;
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1; meta_tready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_meta_valid", 128'(meta_tvalid), 128'(0));
    chk("rst_meta_data", 128'(meta_tdata), 128'(0));
    chk("rst_in_frame", 128'(in_frame), 128'(0));
    chk("rst_tready", 128'(s_tready), 128'(1));
    rstn = 1'b1;
    repeat (2) cycle();

    timer = 72'd400000;
    for (int i = 0; i < 7; i++) begin
      t_first = timer;
`ifdef GET_FRAME_LENGTH_AND_TIMESTAMP_WIDE_EOF_TIMESTAMP_EN
      t_exp = t_first + 72'(tbl[i].beats - 1) * 72'd8000;
`else
      t_exp = t_first;
`endif
      send_frame(tbl[i].beats, tbl[i].last_keep);
      #2;
      chk("tbl_meta_latency", 128'(meta_tvalid), 128'(1));
      chk("tbl_len", 128'(meta_tdata[MW-1:TSW]), 128'(tbl[i].exp_len));
      chk("tbl_ts", 128'(meta_tdata[TSW-1:0]), 128'(t_exp));
      chk("tbl_len8", 128'(d8_meta_tdata[MW8-1:TSW]), 128'(tbl[i].exp_len8));
      meta_tready = 1'b1;
      cycle();
      meta_tready = 1'b0;
    end

    // FIFO full: the fifth frame's tlast beat must wait for a pop.
    for (int f = 0; f < 4; f++) send_frame(2, 8'hFF);
    send_beat(8'hFF, 1'b0);
    s_tdata = {$urandom, $urandom}; s_tkeep = 8'hFF; s_tlast = 1'b1; s_tvalid = 1'b1;
    cycle();
    chk("full_hold", 128'(sampled_tready), 128'(0));
    cycle();
    chk("full_hold2", 128'(sampled_tready), 128'(0));
    meta_tready = 1'b1;
    cycle();
    chk("full_no_pushthru", 128'(sampled_tready), 128'(0));
    meta_tready = 1'b0;
    cycle();
    chk("full_accept", 128'(sampled_tready), 128'(1));
    s_tvalid = 1'b0;
    p0 = pops_total;
    meta_tready = 1'b1;
    repeat (8) cycle();
    chk("full_drain_count", 128'(pops_total - p0), 128'(4));
    meta_tready = 1'b0;

    // Reset in the middle of a frame, then a clean 64-byte frame.
    for (int b = 0; b < 3; b++) send_beat(8'hFF, 1'b0);
    rstn = 1'b0;
    #1;
    chk("midrst_in_frame", 128'(in_frame), 128'(0));
    chk("midrst_meta_valid", 128'(meta_tvalid), 128'(0));
    model_reset();
    @(posedge clk);
    #1;
    timer = timer + 72'd8000;
    rstn = 1'b1;
    t_first = timer;
`ifdef GET_FRAME_LENGTH_AND_TIMESTAMP_WIDE_EOF_TIMESTAMP_EN
    t_exp = t_first + 72'd56000;
`else
    t_exp = t_first;
`endif
    p0 = pops_total;
    send_frame(8, 8'hFF);
    #2;
    chk("midrst_len", 128'(meta_tdata[MW-1:TSW]), 128'(64));
    chk("midrst_ts", 128'(meta_tdata[TSW-1:0]), 128'(t_exp));
    meta_tready = 1'b1;
    repeat (4) cycle();
    chk("midrst_one_meta", 128'(pops_total - p0), 128'(1));

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      s_tdata     = {$urandom, $urandom};
      s_tkeep     = 8'($urandom);
      s_tvalid    = ($urandom_range(0, 3) != 0);
      s_tlast     = ($urandom_range(0, 3) == 0);
      m_tready    = ($urandom_range(0, 4) != 0);
      meta_tready = ($urandom_range(0, 2) == 0);
      cycle();
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1; meta_tready = 1'b1;
    repeat (10) cycle();
    chk("final_fifo_empty", 128'(meta_tvalid), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
